// File: rtl/logic_unit_pipe_if.sv
// Handshaked operand/result bundle for logic_unit_pipe.
// master drives operands and consumes results; slave is the unit.
interface logic_unit_pipe_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             acc_en;
  logic             acc_clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [2:0]       out_op;
  logic             out_zero;
  logic             out_parity;
  logic [WIDTH-1:0] acc_q;

  modport master (
    output in_valid,
    output op,
    output a,
    output b,
    output acc_en,
    output acc_clr,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_op,
    input  out_zero,
    input  out_parity,
    input  acc_q
  );

  modport slave (
    input  in_valid,
    input  op,
    input  a,
    input  b,
    input  acc_en,
    input  acc_clr,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_op,
    output out_zero,
    output out_parity,
    output acc_q
  );
endinterface

// File: rtl/logic_unit_pipe.sv
// Registered bitwise logic unit with elastic output stage,
// accumulator operand mode and zero/parity status flags.
module logic_unit_pipe #(
  parameter int unsigned      WIDTH    = 8,
  parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
  input  logic              clk,
  input  logic              rst,
  logic_unit_pipe_if.slave  bus
);

  typedef enum logic [2:0] {
    OP_NOTA = 3'd0,
    OP_NOTB = 3'd1,
    OP_OR   = 3'd2,
    OP_AND  = 3'd3,
    OP_XOR  = 3'd4,
    OP_NOR  = 3'd5,
    OP_NAND = 3'd6,
    OP_XNOR = 3'd7
  } op_e;

  logic             valid_q;
  logic [WIDTH-1:0] data_q;
  logic [2:0]       op_q;
  logic             zero_q;
  logic             parity_q;
  logic [WIDTH-1:0] acc_r;

  logic             in_ready;
  logic             accept;
  logic [7:0]       op_sel;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] res;

  // Ready depends only on stage state, never on in_valid.
  assign in_ready = !valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;

  assign b_eff  = bus.acc_en ? acc_r : bus.b;
  assign op_sel = 8'b1 << bus.op;

  always_comb begin
    res = '0;
    unique case (1'b1)
      op_sel[OP_NOTA]: res = ~bus.a;
      op_sel[OP_NOTB]: res = ~b_eff;
      op_sel[OP_OR]:   res = bus.a | b_eff;
      op_sel[OP_AND]:  res = bus.a & b_eff;
      op_sel[OP_XOR]:  res = bus.a ^ b_eff;
      op_sel[OP_NOR]:  res = ~(bus.a | b_eff);
      op_sel[OP_NAND]: res = ~(bus.a & b_eff);
      op_sel[OP_XNOR]: res = ~(bus.a ^ b_eff);
      default:         res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      data_q   <= '0;
      op_q     <= 3'd0;
      zero_q   <= 1'b1;
      parity_q <= 1'b0;
    end else if (accept) begin
      valid_q  <= 1'b1;
      data_q   <= res;
      op_q     <= bus.op;
      zero_q   <= (res == '0);
      parity_q <= ^res;
    end else if (bus.out_ready) begin
      valid_q  <= 1'b0;
    end
  end

  // Clear outranks write-back; the op still saw the old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r <= ACC_INIT;
    end else if (bus.acc_clr) begin
      acc_r <= ACC_INIT;
    end else if (accept && bus.acc_en) begin
      acc_r <= res;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = valid_q;
  assign bus.out_data   = data_q;
  assign bus.out_op     = op_q;
  assign bus.out_zero   = zero_q;
  assign bus.out_parity = parity_q;
  assign bus.acc_q      = acc_r;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Bench for logic_unit_pipe: directed steps, random traffic
// against a truth-table model, and a WIDTH=1 gate sweep.
module tb_logic_unit_pipe;

  logic clk;
  logic rst;

  logic_unit_pipe_if #(.WIDTH(8)) bus8 ();
  logic_unit_pipe_if #(.WIDTH(1)) bus1 ();

  logic_unit_pipe #(
    .WIDTH(8),
    .ACC_INIT(8'h00)
  ) u_dut8 (
    .clk(clk),
    .rst(rst),
    .bus(bus8)
  );

  logic_unit_pipe #(
    .WIDTH(1),
    .ACC_INIT(1'b0)
  ) u_dut1 (
    .clk(clk),
    .rst(rst),
    .bus(bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Gate truth tables, bit index = {a_bit, b_bit}.
  logic [3:0] tt [8] = '{
    4'b0011, 4'b0101, 4'b1110, 4'b1000,
    4'b0110, 4'b0001, 4'b0111, 4'b1001
  };

  int n_checks = 0;
  int n_fail   = 0;
  int delivered = 0;

  logic       m_valid;
  logic [7:0] m_data;
  logic [2:0] m_op;
  logic [7:0] m_acc;

  function automatic logic [7:0] ref_f(
    input logic [2:0] f,
    input logic [7:0] x,
    input logic [7:0] y
  );
    logic [7:0] r;
    logic [3:0] row;
    row = tt[f];
    for (int i = 0; i < 8; i++) r[i] = row[{x[i], y[i]}];
    return r;
  endfunction

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, update the model, compare the 8-bit unit.
  task automatic tick();
    logic       acc_ok;
    logic [7:0] beff;
    logic [7:0] r;
    if (rst) begin
      m_valid = 1'b0;
      m_data  = 8'h00;
      m_op    = 3'd0;
      m_acc   = 8'h00;
    end else begin
      acc_ok = bus8.in_valid && (!m_valid || bus8.out_ready);
      if (m_valid && bus8.out_ready) delivered++;
      beff = bus8.acc_en ? m_acc : bus8.b;
      r = ref_f(bus8.op, bus8.a, beff);
      if (acc_ok) begin
        m_valid = 1'b1;
        m_data  = r;
        m_op    = bus8.op;
      end else if (bus8.out_ready) begin
        m_valid = 1'b0;
      end
      if (bus8.acc_clr) m_acc = 8'h00;
      else if (acc_ok && bus8.acc_en) m_acc = r;
    end
    @(posedge clk);
    #1;
    check("m_out_valid", 32'(bus8.out_valid), 32'(m_valid));
    check("m_out_data", 32'(bus8.out_data), 32'(m_data));
    check("m_out_op", 32'(bus8.out_op), 32'(m_op));
    check("m_out_zero", 32'(bus8.out_zero), 32'(m_data == 8'h00));
    check("m_out_parity", 32'(bus8.out_parity),
          32'($countones(m_data) % 2));
    check("m_acc_q", 32'(bus8.acc_q), 32'(m_acc));
    check("m_in_ready", 32'(bus8.in_ready),
          32'(!m_valid || bus8.out_ready));
  endtask

  task automatic drive(
    input logic       v,
    input logic [2:0] f,
    input logic [7:0] x,
    input logic [7:0] y,
    input logic       ae,
    input logic       ac,
    input logic       rdy
  );
    bus8.in_valid  = v;
    bus8.op        = f;
    bus8.a         = x;
    bus8.b         = y;
    bus8.acc_en    = ae;
    bus8.acc_clr   = ac;
    bus8.out_ready = rdy;
  endtask

  logic [7:0] sweep_exp [8] = '{
    8'h5A, 8'hC3, 8'hBD, 8'h24, 8'h99, 8'h42, 8'hDB, 8'h66
  };

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    logic [3:0] row;
    rst = 1'b1;
    drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    bus1.in_valid  = 1'b0;
    bus1.op        = 3'd0;
    bus1.a         = 1'b0;
    bus1.b         = 1'b0;
    bus1.acc_en    = 1'b0;
    bus1.acc_clr   = 1'b0;
    bus1.out_ready = 1'b1;

    tick();
    tick();
    rst = 1'b0;
    check("rst_valid", 32'(bus8.out_valid), 32'd0);
    check("rst_data", 32'(bus8.out_data), 32'h00);
    check("rst_zero", 32'(bus8.out_zero), 32'd1);
    check("rst_parity", 32'(bus8.out_parity), 32'd0);
    check("rst_acc", 32'(bus8.acc_q), 32'h00);
    check("rst_in_ready", 32'(bus8.in_ready), 32'd1);
    tick();

    for (int f = 0; f < 8; f++) begin
      drive(1'b1, 3'(f), 8'hA5, 8'h3C, 1'b0, 1'b0, 1'b1);
      tick();
      check("sweep_data", 32'(bus8.out_data), 32'(sweep_exp[f]));
      check("sweep_valid", 32'(bus8.out_valid), 32'd1);
      check("sweep_parity", 32'(bus8.out_parity), 32'd0);
      check("sweep_zero", 32'(bus8.out_zero), 32'd0);
    end
    drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    tick();

    d0 = delivered;
    drive(1'b1, 3'd3, 8'hFF, 8'h0F, 1'b0, 1'b0, 1'b1);
    tick();
    check("bp_first", 32'(bus8.out_data), 32'h0F);
    drive(1'b1, 3'd2, 8'hF0, 8'h01, 1'b0, 1'b0, 1'b0);
    #1;
    check("bp_in_ready", 32'(bus8.in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_data", 32'(bus8.out_data), 32'h0F);
      check("bp_hold_valid", 32'(bus8.out_valid), 32'd1);
      check("bp_hold_ready", 32'(bus8.in_ready), 32'd0);
    end
    bus8.out_ready = 1'b1;
    tick();
    check("bp_second", 32'(bus8.out_data), 32'hF1);
    bus8.in_valid = 1'b0;
    tick();
    check("bp_delivered", 32'(delivered - d0), 32'd2);

    drive(1'b1, 3'd4, 8'h11, 8'h00, 1'b1, 1'b0, 1'b1);
    tick();
    check("acc1_data", 32'(bus8.out_data), 32'h11);
    bus8.a = 8'h22;
    tick();
    check("acc2_data", 32'(bus8.out_data), 32'h33);
    bus8.a = 8'h33;
    tick();
    check("acc3_data", 32'(bus8.out_data), 32'h00);
    check("acc3_zero", 32'(bus8.out_zero), 32'd1);
    check("acc3_acc", 32'(bus8.acc_q), 32'h00);

    drive(1'b1, 3'd2, 8'h0F, 8'hAA, 1'b1, 1'b0, 1'b1);
    tick();
    check("clr_pre_acc", 32'(bus8.acc_q), 32'h0F);
    drive(1'b1, 3'd2, 8'hF0, 8'hAA, 1'b1, 1'b1, 1'b1);
    tick();
    check("clr_data", 32'(bus8.out_data), 32'hFF);
    check("clr_acc", 32'(bus8.acc_q), 32'h00);
    drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    tick();

    drive(1'b1, 3'd2, 8'h55, 8'h00, 1'b1, 1'b0, 1'b1);
    tick();
    drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    check("stall_valid", 32'(bus8.out_valid), 32'd1);
    check("stall_acc", 32'(bus8.acc_q), 32'h55);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_stall_valid", 32'(bus8.out_valid), 32'd0);
    check("rst_stall_acc", 32'(bus8.acc_q), 32'h00);
    check("rst_stall_ready", 32'(bus8.in_ready), 32'd1);

    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      drive($urandom_range(0, 3) != 0, 3'($urandom),
            8'($urandom), 8'($urandom), 1'($urandom),
            $urandom_range(0, 15) == 0,
            $urandom_range(0, 3) != 0);
      tick();
    end
    rst = 1'b0;
    drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    tick();

    for (int f = 0; f < 8; f++) begin
      for (int ab = 0; ab < 4; ab++) begin
        bus1.in_valid = 1'b1;
        bus1.op = 3'(f);
        bus1.a  = ab[1];
        bus1.b  = ab[0];
        tick();
        row = tt[f];
        check("w1_data", 32'(bus1.out_data), 32'(row[ab]));
        check("w1_op", 32'(bus1.out_op), 32'(f));
      end
    end
    bus1.in_valid = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, registered successor to the fixed 1-bit gate set: one WIDTH-bit bitwise logic unit with opcode-selected function (NOT a, NOT b, OR, AND, XOR, NOR, NAND, XNOR).
- Adds a valid/ready handshaked output stage, an accumulator mode (operand b replaced by a running result register), and zero/parity status flags.
- Sits between a producer and a consumer as a one-stage elastic pipeline element in DLD lab datapaths.

Parameters:
WIDTH, 8, operand/result width in bits (>=1)
ACC_INIT, 0, accumulator value after reset and after acc_clr (WIDTH bits)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand/opcode present
in_ready  output  1  block can accept this cycle
op  input  3  function select: 0 NOT a, 1 NOT b, 2 OR, 3 AND, 4 XOR, 5 NOR, 6 NAND, 7 XNOR
a  input  WIDTH  operand a
b  input  WIDTH  operand b (ignored when acc_en=1)
acc_en  input  1  accumulate mode: use acc_q as operand b, write result to acc_q
acc_clr  input  1  load accumulator with ACC_INIT
out_valid  output  1  result held
out_ready  input  1  consumer accepts result
out_data  output  WIDTH  registered result
out_op  output  3  opcode that produced out_data
out_zero  output  1  out_data == 0
out_parity  output  1  XOR-reduction of out_data
acc_q  output  WIDTH  accumulator register

Behaviour:
- Reset (rst=1 at clk edge): out_valid=0, out_data=0, out_op=0, out_zero=1, out_parity=0, acc_q=ACC_INIT. Reset wins over every other input; a transfer in flight is dropped.
- in_ready = !out_valid || out_ready (combinational; no combinational path from in_valid to in_ready).
- Accept = in_valid && in_ready. On accept: out_data <= f(op, a, b_eff), out_op <= op, out_zero/out_parity computed from the new result, out_valid <= 1. b_eff = acc_q if acc_en else b.
- Latency: exactly 1 cycle from accept to out_valid. Throughput 1 result/cycle when out_ready held high.
- Output drain: out_valid && out_ready && !accept -> out_valid <= 0; out_data/out_op/flags hold last value.
- Stall: out_valid && !out_ready -> in_ready=0; out_data, out_op, flags, out_valid stable until accepted.
- Simultaneous drain and accept: new result replaces old in same edge, out_valid stays 1.
- Ops 0/1 are unary: NOT a ignores b_eff; NOT b returns ~b_eff (in acc mode = ~acc_q).
- Accumulator: on accept with acc_en=1, acc_q <= result. acc_q unchanged on accepts with acc_en=0 and when not accepting.
- acc_clr=1: acc_q <= ACC_INIT at the edge, independent of in_valid/in_ready. If same cycle as an accepted acc_en op: the op uses the old acc_q for its result (out_data reflects it), but acc_q <= ACC_INIT (clear has priority over write-back).
- acc_en, op, a, b sampled only on accept; values during non-accept cycles have no effect.
- Purely bitwise: no carries, bit i of result depends only on bit i of operands. WIDTH=1 must reproduce the 1-bit gate truth tables exactly.

Test Plan:
- Reset then idle: rst=1 two cycles -> out_valid=0, out_data=0x00, out_zero=1, out_parity=0, acc_q=0x00, in_ready=1.
- Op sweep, out_ready=1, a=0xA5, b=0x3C, op 0..7 back-to-back -> out_data 0x5A,0xC3,0xBD,0x24,0x99,0x42,0xDB,0x66 one cycle after each accept, out_parity 0,0,0,0,0,0,0,0, out_zero=0, no bubbles.
- Backpressure: accept op=3 a=0xFF b=0x0F, hold out_ready=0 for 3 cycles while in_valid=1 with op=2 a=0xF0 b=0x01 -> in_ready=0, out_data stays 0x0F for 3 cycles; release out_ready -> next cycle out_data=0xF1, exactly two results delivered.
- Accumulate: ACC_INIT=0; acc_en=1 op=4 with a=0x11, 0x22, 0x33 -> out_data 0x11, 0x33, 0x00; acc_q 0x00 after third; out_zero=1 on third.
- Clear collision: acc_q=0x0F; accept acc_en=1 op=2 a=0xF0 with acc_clr=1 -> out_data=0xFF, acc_q=0x00.
- Reset mid-stall: out_valid=1, out_ready=0, assert rst -> next edge out_valid=0, acc_q=ACC_INIT, in_ready=1; WIDTH=1 build: all 4 a/b combos x 8 ops match gate truth tables.
